// File: rtl/ysyx_23060201_pkg.sv
// Shared constants and types for the GPR write-back controller.
//   GPR_ADDR_WIDTH / GPR_NUM : GPR index width and register count
//   DATA_WIDTH               : GPR data width
//   PEND_W                   : per-register pending-write counter width
//   REQ_EXU / REQ_LSU        : requester ids, also the bit positions in req/gnt vectors
package ysyx_23060201_pkg;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_NUM        = 1 << GPR_ADDR_WIDTH;
  localparam int DATA_WIDTH     = 32;
  localparam int PEND_W         = 2;

  localparam int REQ_EXU = 0;
  localparam int REQ_LSU = 1;

  typedef enum logic {
    LAST_EXU = 1'b0,
    LAST_LSU = 1'b1
  } last_gnt_e;
endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, indexed by REQ_EXU / REQ_LSU
//   advance    : a grant was actually taken this cycle; the pointer moves only then
//   gnt[1:0]   : one-hot grant, combinational from req
//   last_gnt   : registered id of the most recent winner (reset: EXU)
module ysyx_23060201_rr_arb2
  import ysyx_23060201_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_gnt
);

  last_gnt_e last_reg;

  assign last_gnt = last_reg;

  // On a tie the requester that did not win last time takes the slot.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_reg == LAST_EXU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= LAST_EXU;
    end else if (advance) begin
      last_reg <= gnt[REQ_LSU] ? LAST_LSU : LAST_EXU;
    end
  end

endmodule

// File: rtl/ysyx_23060201_gpr_wb_ctrl.sv
// GPR write-back controller: arbitrates the single GPR write port between EXU
// and LSU, registers the winning write for one cycle, and keeps a per-register
// pending-write scoreboard used by decode for RAW stalls.
//   exu_* / lsu_*     : valid/ready result producers (ready is combinational)
//   issue_*           : decode announces a new in-flight write to issue_rd
//   chk_ren/rs1/rs2   : source operands checked against the scoreboard
//   raw_stall         : a used source still has a pending write
//   gpr_wen/waddr/wdata : registered GPR write port
module ysyx_23060201_gpr_wb_ctrl #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int PEND_W         = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exu_valid,
  output logic                      exu_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0]     exu_wdata,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] issue_rd,
  input  logic [1:0]                chk_ren,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      raw_stall,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata
);
  import ysyx_23060201_pkg::REQ_EXU;
  import ysyx_23060201_pkg::REQ_LSU;

  localparam int NREG = 1 << GPR_ADDR_WIDTH;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // ---------------- arbitration ----------------
  logic [1:0]                req;
  logic [1:0]                gnt;
  logic                      any_gnt;
  logic                      last_gnt;
  logic [GPR_ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0]     win_wdata;

  assign req[REQ_EXU] = exu_valid;
  assign req[REQ_LSU] = lsu_valid;
  assign any_gnt      = |gnt;

  ysyx_23060201_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .advance  (any_gnt),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  assign exu_ready = gnt[REQ_EXU];
  assign lsu_ready = gnt[REQ_LSU];
  assign win_rd    = gnt[REQ_LSU] ? lsu_rd    : exu_rd;
  assign win_wdata = gnt[REQ_LSU] ? lsu_wdata : exu_wdata;

  // ---------------- registered write port ----------------
  // A grant to x0 still completes the handshake but never raises gpr_wen,
  // so it also never decrements a counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= any_gnt && (win_rd != '0);
      if (any_gnt) begin
        gpr_waddr <= win_rd;
        gpr_wdata <= win_wdata;
      end
    end
  end

  // ---------------- pending-write scoreboard ----------------
  logic [PEND_W-1:0] cnt_reg [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic              issue_fire;

  assign issue_ready = (cnt_reg[issue_rd] != PEND_MAX);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Decrement at the commit edge (gpr_wen high), so the source clears only
  // once the GPR file already holds the value.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_incdec
      assign inc_vec[gi] = issue_fire && (issue_rd == GPR_ADDR_WIDTH'(gi));
      assign dec_vec[gi] = gpr_wen && (gpr_waddr != '0) && (gpr_waddr == GPR_ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt_reg[i] <= cnt_reg[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt_reg[i] <= cnt_reg[i] - 1'b1;
      end
    end
  end

  assign raw_stall = (chk_ren[0] && (cnt_reg[chk_rs1] != '0)) ||
                     (chk_ren[1] && (cnt_reg[chk_rs2] != '0));

  // A commit with nothing pending means a write was never issued; on a tie
  // the previous winner must not be granted again.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        if (dec_vec[i] && !inc_vec[i]) assert (cnt_reg[i] != '0);
      end
      if (exu_valid && lsu_valid) assert (gnt[last_gnt] == 1'b0);
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_gpr_wb_ctrl.sv
module tb_ysyx_23060201_gpr_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_wdata;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [1:0]  chk_ren;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        raw_stall;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  int checks = 0;
  int errors = 0;

  ysyx_23060201_gpr_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_wdata   (exu_wdata),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_wdata   (lsu_wdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rd    (issue_rd),
    .chk_ren     (chk_ren),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .raw_stall   (raw_stall),
    .gpr_wen     (gpr_wen),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1-2 units after that, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 0; exu_rd = 0; exu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
    issue_valid = 0; issue_rd = 0;
    chk_ren = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    chk_ren = 2'b11; chk_rs1 = 5'd1; chk_rs2 = 5'd2;
    #2;
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", gpr_wen); end
    checks++; if (gpr_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", gpr_waddr); end
    checks++; if (gpr_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", gpr_wdata); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", raw_stall); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b want 1", issue_ready); end
    tick();
    rst_n = 1;
    chk_ren = 0;
    tick();
  endtask

  task automatic test_mid_reset();
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0;
    exu_valid = 1; exu_rd = 5'd5; exu_wdata = 32'hCAFE0005;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL midrst_exu_ready got %b want 1", exu_ready); end
    tick();
    exu_valid = 0;
    checks++; if (gpr_wen !== 1'b1) begin errors++; $display("FAIL midrst_wen_before got %b want 1", gpr_wen); end
    rst_n = 0;
    chk_ren = 2'b01; chk_rs1 = 5'd5; issue_rd = 5'd5;
    #1;
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen got %b want 0", gpr_wen); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", raw_stall); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen_after got %b want 0", gpr_wen); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall_after got %b want 0", raw_stall); end
    idle_inputs();
  endtask

  task automatic test_single_exu();
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_valid = 0;
    chk_ren = 2'b01; chk_rs1 = 5'd3;
    exu_valid = 1; exu_rd = 5'd3; exu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL single_exu_ready got %b want 1", exu_ready); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL single_lsu_ready got %b want 0", lsu_ready); end
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL single_stall_N got %b want 1", raw_stall); end
    tick();
    exu_valid = 0;
    #1;
    checks++; if (gpr_wen !== 1'b1) begin errors++; $display("FAIL single_wen got %b want 1", gpr_wen); end
    checks++; if (gpr_waddr !== 5'd3) begin errors++; $display("FAIL single_waddr got %0d want 3", gpr_waddr); end
    checks++; if (gpr_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got %h want deadbeef", gpr_wdata); end
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL single_stall_N1 got %b want 1", raw_stall); end
    tick();
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL single_stall_N2 got %b want 0", raw_stall); end
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL single_wen_N2 got %b want 0", gpr_wen); end
    idle_inputs();
  endtask

  task automatic test_x0_write();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_wdata = 32'h1234;
    chk_ren = 2'b10; chk_rs2 = 5'd0;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_lsu_ready got %b want 1", lsu_ready); end
    checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL x0_exu_ready got %b want 0", exu_ready); end
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b want 0", gpr_wen); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", raw_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic       exp_exu [4];
    logic [4:0] exp_addr [4];
    exp_exu[0] = 1; exp_exu[1] = 0; exp_exu[2] = 1; exp_exu[3] = 0;
    for (int i = 0; i < 4; i++) exp_addr[i] = exp_exu[i] ? 5'd1 : 5'd2;
    // Two writes in flight to each of x1 and x2.
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_rd = (i < 2) ? 5'd1 : 5'd2;
      tick();
    end
    issue_valid = 0;
    exu_valid = 1; exu_rd = 5'd1; exu_wdata = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (exu_ready !== exp_exu[i] || lsu_ready !== !exp_exu[i])
        begin errors++; $display("FAIL contend_gnt%0d got exu=%b lsu=%b want exu=%b lsu=%b", i, exu_ready, lsu_ready, exp_exu[i], !exp_exu[i]); end
      if (i > 0) begin
        checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== exp_addr[i-1])
          begin errors++; $display("FAIL contend_wr%0d got wen=%b addr=%0d want wen=1 addr=%0d", i-1, gpr_wen, gpr_waddr, exp_addr[i-1]); end
      end
      tick();
    end
    exu_valid = 0; lsu_valid = 0;
    chk_ren = 2'b11; chk_rs1 = 5'd1; chk_rs2 = 5'd2;
    #1;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd2 || gpr_wdata !== 32'h22)
      begin errors++; $display("FAIL contend_wr3 got wen=%b addr=%0d data=%h want wen=1 addr=2 data=22", gpr_wen, gpr_waddr, gpr_wdata); end
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL contend_stall_x2 got %b want 1", raw_stall); end
    tick();
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL contend_stall_clear got %b want 0", raw_stall); end
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL contend_wen_idle got %b want 0", gpr_wen); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    issue_valid = 1; issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready%0d got %b want 1", i, issue_ready); end
      tick();
    end
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b want 0", issue_ready); end
    tick();
    issue_valid = 0;
    exu_valid = 1; exu_rd = 5'd7; exu_wdata = 32'h77;
    tick();
    exu_valid = 0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_commit_cycle got %b want 0", issue_ready); end
    tick();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_after_commit got %b want 1", issue_ready); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    exu_valid = 1; exu_rd = 5'd9; exu_wdata = 32'h99;
    tick();
    exu_valid = 0;
    issue_valid = 1; issue_rd = 5'd9;
    chk_ren = 2'b01; chk_rs1 = 5'd9;
    #1;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd9)
      begin errors++; $display("FAIL same_commit got wen=%b addr=%0d want wen=1 addr=9", gpr_wen, gpr_waddr); end
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL same_stall_during got %b want 1", raw_stall); end
    tick();
    issue_valid = 0;
    #1;
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL same_stall_after got %b want 1", raw_stall); end
    // One more commit must drain the single remaining pending write.
    exu_valid = 1; exu_rd = 5'd9; exu_wdata = 32'h98;
    tick();
    exu_valid = 0;
    tick();
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL same_drain got %b want 0", raw_stall); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_single_exu();
    test_x0_write();
    test_contention();
    test_saturation();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
